// File: rtl/mem_access_unit.sv
// Load/store unit between an RV32I-style request port and a single-ported
// word memory. It formats loads and turns sub-word stores into read-modify-write
// sequences. Illegal and misaligned requests answer without touching memory.
module mem_access_unit #(
    parameter int SIZE = 1024
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_misaligned,
    output logic        rsp_illegal,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WR, RESP} state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_mis_q, rsp_mis_d;
    logic        rsp_ill_q, rsp_ill_d;

    logic        req_illegal;
    logic        req_misaligned;
    logic [31:0] load_data;
    logic [31:0] shifted;

    // Classify the incoming request: illegal code / out of range, then alignment
    always_comb begin
        req_illegal    = 1'b0;
        req_misaligned = 1'b0;
        if (req_we) begin
            req_illegal = (req_funct3 != 3'b000) && (req_funct3 != 3'b001) &&
                          (req_funct3 != 3'b010);
        end else begin
            req_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                          (req_funct3 == 3'b111);
        end
        if ({2'b00, req_addr[31:2]} >= 32'(SIZE)) begin
            req_illegal = 1'b1;
        end
        if (req_funct3[1:0] == 2'b01) begin
            req_misaligned = req_addr[0];
        end else if (req_funct3[1:0] == 2'b10) begin
            req_misaligned = (req_addr[1:0] != 2'b00);
        end
    end

    // Extract and extend the addressed byte/halfword from the memory word
    always_comb begin
        shifted   = mem_rdata >> {addr_q[1:0], 3'b000};
        load_data = mem_rdata;
        case (funct3_q)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_data = {24'h0, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  load_data = {16'h0, shifted[15:0]};
            default: load_data = mem_rdata;
        endcase
    end

    // Build the full write word: whole word for SW, lane merge into the read-back word otherwise
    always_comb begin
        mem_wdata = merge_q;
        if (funct3_q[1:0] == 2'b10) begin
            mem_wdata = wdata_q;
        end else if (funct3_q[1:0] == 2'b01) begin
            if (addr_q[1]) begin
                mem_wdata = {wdata_q[15:0], merge_q[15:0]};
            end else begin
                mem_wdata = {merge_q[31:16], wdata_q[15:0]};
            end
        end else begin
            case (addr_q[1:0])
                2'b00:   mem_wdata = {merge_q[31:8], wdata_q[7:0]};
                2'b01:   mem_wdata = {merge_q[31:16], wdata_q[7:0], merge_q[7:0]};
                2'b10:   mem_wdata = {merge_q[31:24], wdata_q[7:0], merge_q[15:0]};
                default: mem_wdata = {wdata_q[7:0], merge_q[23:0]};
            endcase
        end
    end

    // Next-state logic; response fields only change on the edge into RESP so they hold between responses
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        merge_d     = merge_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_mis_d   = rsp_mis_q;
        rsp_ill_d   = rsp_ill_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    if (req_illegal || req_misaligned) begin
                        state_d     = RESP;
                        rsp_rdata_d = 32'h0;
                        rsp_ill_d   = req_illegal;
                        rsp_mis_d   = !req_illegal;
                    end else if (!req_we) begin
                        state_d = LOAD;
                    end else if (req_funct3[1:0] == 2'b10) begin
                        state_d = WR;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end
            LOAD: begin
                rsp_rdata_d = load_data;
                rsp_mis_d   = 1'b0;
                rsp_ill_d   = 1'b0;
                state_d     = RESP;
            end
            RMW_RD: begin
                merge_d = mem_rdata;
                state_d = WR;
            end
            WR: begin
                rsp_rdata_d = 32'h0;
                rsp_mis_d   = 1'b0;
                rsp_ill_d   = 1'b0;
                state_d     = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            merge_q     <= 32'h0;
            rsp_rdata_q <= 32'h0;
            rsp_mis_q   <= 1'b0;
            rsp_ill_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            merge_q     <= merge_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_mis_q   <= rsp_mis_d;
            rsp_ill_q   <= rsp_ill_d;
        end
    end

    // Output decode; mem_we is gated by RESET_N so a reset edge never writes
    always_comb begin
        req_ready      = (state_q == IDLE);
        rsp_valid      = (state_q == RESP);
        rsp_rdata      = rsp_rdata_q;
        rsp_misaligned = rsp_mis_q;
        rsp_illegal    = rsp_ill_q;
        mem_we         = (state_q == WR) && RESET_N;
        mem_addr       = (state_q == IDLE) ? {req_addr[31:2], 2'b00} : {addr_q[31:2], 2'b00};
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed requests push expected
// responses; a monitor pops and compares whenever rsp_valid is seen.
module tb_mem_access_unit;

    localparam int SIZE = 64;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_misaligned;
    logic        rsp_illegal;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    logic [31:0] mem [SIZE];
    logic        tb_we;
    logic [5:0]  tb_waddr;
    logic [31:0] tb_wdata;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        ill;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   we_pulses = 0;

    mem_access_unit #(.SIZE(SIZE)) dut (
        .CLK(CLK),
        .RESET_N(RESET_N),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_funct3(req_funct3),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_misaligned(rsp_misaligned),
        .rsp_illegal(rsp_illegal),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    always #5 CLK = ~CLK;

    // Word memory: combinational read, DUT write port has priority over preload port
    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge CLK) begin
        if (mem_we) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end else if (tb_we) begin
            mem[tb_waddr] <= tb_wdata;
        end
    end

    // Edge counter and write-pulse counter
    always @(posedge CLK) cyc <= cyc + 1;
    always @(negedge CLK) if (mem_we) we_pulses <= we_pulses + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every response must match the oldest expected entry
    always @(negedge CLK) begin
        exp_t e;
        if (rsp_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_rsp actual=1 required=0 at cycle %0d", cyc);
            end else begin
                e = sbq.pop_front();
                checkOutput("rsp_rdata", rsp_rdata, e.rdata);
                checkOutput("rsp_flags", {30'h0, rsp_misaligned, rsp_illegal}, {30'h0, e.mis, e.ill});
                checkOutput("rsp_cycle", cyc, e.cyc);
            end
        end
    end

    // Called at a negedge; presents a request and waits (bounded) for its acceptance.
    // lat is the number of cycles from accept to rsp_valid (1 = the cycle right after accept).
    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic push,
                                 input logic [31:0] exp_rdata, input logic exp_mis,
                                 input logic exp_ill, input int lat, output int acc_cyc);
        exp_t e;
        bit   ok = 0;
        acc_cyc    = -1;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        for (int i = 0; i < 50; i++) begin
            if (req_ready) begin
                acc_cyc = cyc + 1;
                if (push) begin
                    e.rdata = exp_rdata;
                    e.mis   = exp_mis;
                    e.ill   = exp_ill;
                    e.cyc   = acc_cyc + lat - 1;
                    sbq.push_back(e);
                end
                @(posedge CLK);
                @(negedge CLK);
                ok = 1;
                break;
            end
            @(negedge CLK);
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout actual=req_ready_low required=accept addr=0x%08h", addr);
        end
    endtask

    // Drop req_valid and wait (bounded) for all expected responses
    task automatic drain();
        req_valid = 1'b0;
        for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge CLK);
        if (sbq.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL rsp_timeout actual=%0d pending required=0", sbq.size());
            sbq.delete();
        end
        @(negedge CLK);
    endtask

    initial begin
        int acc;
        int acc2;
        int pulses;
        RESET_N    = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        tb_we      = 1'b0;
        tb_waddr   = 6'd0;
        tb_wdata   = 32'h0;
        @(negedge CLK);
        tb_we = 1'b1; tb_waddr = 6'd4;  tb_wdata = 32'h8899AABB; @(negedge CLK);
        tb_waddr = 6'd8;  tb_wdata = 32'h11223344; @(negedge CLK);
        tb_waddr = 6'd9;  tb_wdata = 32'hCAFEF00D; @(negedge CLK);
        tb_waddr = 6'd16; tb_wdata = 32'h00000000; @(negedge CLK);
        tb_we = 1'b0;

        // Reset state
        checkOutput("reset_req_ready", {31'h0, req_ready}, 32'h1);
        checkOutput("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("reset_mem_we", {31'h0, mem_we}, 32'h0);
        RESET_N = 1'b1;
        @(negedge CLK);

        // Loads from word 0x10 = 0x8899AABB
        applyStimulus(1'b0, 3'b000, 32'h12, 32'h0, 1'b1, 32'hFFFFFF99, 1'b0, 1'b0, 2, acc); drain();
        applyStimulus(1'b0, 3'b100, 32'h12, 32'h0, 1'b1, 32'h00000099, 1'b0, 1'b0, 2, acc); drain();
        applyStimulus(1'b0, 3'b001, 32'h10, 32'h0, 1'b1, 32'hFFFFAABB, 1'b0, 1'b0, 2, acc); drain();
        applyStimulus(1'b0, 3'b101, 32'h12, 32'h0, 1'b1, 32'h00008899, 1'b0, 1'b0, 2, acc); drain();
        applyStimulus(1'b0, 3'b000, 32'h11, 32'h0, 1'b1, 32'hFFFFFFAA, 1'b0, 1'b0, 2, acc); drain();
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 32'h8899AABB, 1'b0, 1'b0, 2, acc); drain();

        // SB into word 0x20 = 0x11223344
        pulses = we_pulses;
        applyStimulus(1'b1, 3'b000, 32'h21, 32'h000000EE, 1'b1, 32'h0, 1'b0, 1'b0, 3, acc); drain();
        checkOutput("sb_mem_word", mem[8], 32'h1122EE44);
        checkOutput("sb_we_pulses", we_pulses - pulses, 32'd1);

        // SH upper lane of the same word
        applyStimulus(1'b1, 3'b001, 32'h22, 32'h1234ABCD, 1'b1, 32'h0, 1'b0, 1'b0, 3, acc); drain();
        checkOutput("sh_mem_word", mem[8], 32'hABCDEE44);

        // Error cases: misaligned, out of range, illegal codes, illegal-over-misaligned
        pulses = we_pulses;
        applyStimulus(1'b1, 3'b001, 32'h33, 32'h0000FFFF, 1'b1, 32'h0, 1'b1, 1'b0, 1, acc); drain();
        applyStimulus(1'b0, 3'b010, 32'h100, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1, 1, acc); drain();
        applyStimulus(1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1, 1, acc); drain();
        applyStimulus(1'b1, 3'b011, 32'h13, 32'h5, 1'b1, 32'h0, 1'b0, 1'b1, 1, acc); drain();
        applyStimulus(1'b0, 3'b010, 32'h12, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, 1, acc); drain();
        checkOutput("err_we_pulses", we_pulses - pulses, 32'd0);
        checkOutput("err_mem_word", mem[8], 32'hABCDEE44);

        // Leave a non-zero rdata so the reset clear is visible
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 32'h8899AABB, 1'b0, 1'b0, 2, acc); drain();

        // Reset during WR of an SB: no write, no response, ready right after release
        applyStimulus(1'b1, 3'b000, 32'h25, 32'h00000077, 1'b0, 32'h0, 1'b0, 1'b0, 3, acc);
        @(negedge CLK);
        checkOutput("rst_wr_mem_we_before", {31'h0, mem_we}, 32'h1);
        RESET_N   = 1'b0;
        req_valid = 1'b0;
        #1;
        checkOutput("rst_wr_mem_we_gated", {31'h0, mem_we}, 32'h0);
        @(negedge CLK);
        RESET_N = 1'b1;
        checkOutput("rst_release_ready", {31'h0, req_ready}, 32'h1);
        checkOutput("rst_release_rdata", rsp_rdata, 32'h0);
        repeat (4) @(negedge CLK);
        checkOutput("rst_mem_unchanged", mem[9], 32'hCAFEF00D);

        // Back-to-back SW then LH with req_valid held high
        applyStimulus(1'b1, 3'b010, 32'h40, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0, 1'b0, 2, acc);
        applyStimulus(1'b0, 3'b001, 32'h42, 32'h0, 1'b1, 32'hFFFFDEAD, 1'b0, 1'b0, 2, acc2);
        drain();
        checkOutput("b2b_accept_gap", acc2 - acc, 32'd3);
        checkOutput("b2b_mem_word", mem[16], 32'hDEADBEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have one parameter: SIZE, default 1024, meaning backing memory depth in 32-bit words.
REQ-002 The block SHALL have the port CLK, input, 1 bit: the single clock, rising edge active.
REQ-003 The block SHALL have the port RESET_N, input, 1 bit: synchronous, active-low reset.
REQ-004 The request-side ports SHALL be:
- req_valid, input, 1 bit: request present.
- req_ready, output, 1 bit: block can accept a request.
- req_we, input, 1 bit: 1 = store, 0 = load.
- req_funct3, input, 3 bits: RV32I width/sign code.
- req_addr, input, 32 bits: byte address.
- req_wdata, input, 32 bits: store data, right-aligned.
REQ-005 The response-side ports SHALL be:
- rsp_valid, output, 1 bit: one-cycle response strobe.
- rsp_rdata, output, 32 bits: formatted load result.
- rsp_misaligned, output, 1 bit: alignment fault.
- rsp_illegal, output, 1 bit: illegal funct3 or address out of range.
REQ-006 The memory-side ports SHALL be:
- mem_addr, output, 32 bits: word-aligned byte address to the word memory.
- mem_wdata, output, 32 bits: full-word write data.
- mem_we, output, 1 bit: write enable.
- mem_rdata, input, 32 bits: combinational read data for mem_addr.

Function
REQ-007 The FSM SHALL have the states IDLE, LOAD, RMW_RD, WR and RESP; req_ready SHALL be 1 only in IDLE.
REQ-008 A request SHALL be accepted on a rising edge with req_valid=1 in IDLE; req_we, req_funct3, req_addr and req_wdata SHALL be latched at that edge.
REQ-009 The legal codes SHALL be:
- loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- stores: 000 SB, 001 SH, 010 SW.
- every other code is illegal.
REQ-010 An address SHALL be out of range when req_addr[31:2] >= SIZE.
REQ-011 An access SHALL be misaligned for a halfword with addr[0]=1, or for a word with addr[1:0]!=0.
REQ-012 Error precedence SHALL be illegal over misaligned; an errored request SHALL go IDLE->RESP, never assert mem_we, and return rsp_rdata=0.
REQ-013 Legal transitions SHALL be:
- load: IDLE->LOAD->RESP.
- SW: IDLE->WR->RESP.
- SB/SH: IDLE->RMW_RD->WR->RESP.
- RESP->IDLE unconditionally.
REQ-014 rsp_valid SHALL be high for exactly one cycle, in RESP. Latency from the accept edge to rsp_valid SHALL be:
- error: 1 cycle.
- load and SW: 2 cycles.
- SB/SH: 3 cycles.
REQ-015 mem_addr SHALL equal {latched_addr[31:2], 2'b00} in every non-IDLE state, and {req_addr[31:2], 2'b00} in IDLE.
REQ-016 In LOAD, the block SHALL select the byte or halfword from mem_rdata using addr[1:0], sign-extend for LB/LH, zero-extend for LBU/LHU, and register the result into rsp_rdata at the LOAD->RESP edge.
REQ-017 In RMW_RD, mem_rdata SHALL be registered into a merge buffer.
REQ-018 In WR, mem_wdata SHALL be:
- SW: req_wdata.
- SB: the merge buffer with lane addr[1:0] replaced by wdata[7:0].
- SH: the merge buffer with halfword lane addr[1] replaced by wdata[15:0].
REQ-019 mem_we SHALL equal (state==WR) AND RESET_N, so no write occurs on a reset edge.
REQ-020 For stores, rsp_rdata SHALL be 0.
REQ-021 rsp_misaligned, rsp_illegal and rsp_rdata SHALL hold their values from RESP until the next response; only rsp_valid qualifies them.
REQ-022 req_valid asserted in any non-IDLE state SHALL be ignored; the requester holds it until req_ready=1.

Reset
REQ-023 When RESET_N=0 at a rising edge, the block SHALL enter IDLE with rsp_valid=0, rsp_rdata=0, rsp_misaligned=0, rsp_illegal=0, merge buffer=0 and mem_we=0 from the following cycle.
REQ-024 A reset in LOAD, RMW_RD, WR or RESP SHALL abandon the access with no memory write and no rsp_valid; the first cycle after RESET_N returns to 1 SHALL show req_ready=1.

Verification
REQ-025 Word 0x10 = 0x8899AABB; LB at addr 0x12 -> rsp_rdata=0xFFFFFF99 two cycles after accept; LBU at the same address -> 0x00000099.
REQ-026 Word 0x20 = 0x11223344; SB at addr 0x21 with wdata 0x000000EE -> word 0x20 = 0x1122EE44, mem_we high for exactly one cycle, rsp_valid three cycles after accept.
REQ-027 SH at addr 0x33 -> rsp_misaligned=1 and rsp_valid one cycle after accept, with no mem_we pulse; LW at addr 4*SIZE -> rsp_illegal=1.
REQ-028 SB issued, RESET_N driven low during the WR cycle -> memory unchanged, no rsp_valid, req_ready=1 in the first cycle after reset is released.
REQ-029 Back-to-back SW 0xDEADBEEF to 0x40 followed by LH at 0x42, with req_valid held high -> the second request is accepted only in IDLE after RESP, and returns rsp_rdata=0xFFFFDEAD.
